hwag_angle_sched: RTL and testbench

Angle-domain output scheduler for the HWAG core. It owns CH_NUM output channels, each programmed with a set angle and a clear angle. A single shared equality comparator is time-multiplexed over the channels against the running ACNT2 angle, and each channel output is driven high from its set angle to its clear angle. It sits downstream of the ACNT2 counter and is gated by the core's synchronisation flag.

---
 rtl/hwag_angle_sched.sv | 131 +++++++++++++
 tb/tb_hwag_angle_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hwag_angle_sched.sv
// hwag_angle_sched: angle-domain output scheduler.
// CH_NUM channels each hold a set/clear angle pair. One equality compare per
// cycle is rotated over the channels against the ACNT2 angle. A channel output
// is high from its set-angle hit until its clear-angle hit.
// Optional feature macro: HWAG_SCHED_REARM_EN (when defined, a clear hit
// returns the channel to ARMED so it fires every revolution).

// Per-channel state, compare and output register.
module hwag_sched_ch #(
  parameter int ACNT_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  sync,
  input  logic                  wr_hit,
  input  logic [ACNT_WIDTH-1:0] wr_set,
  input  logic [ACNT_WIDTH-1:0] wr_clr,
  input  logic                  wr_arm,
  input  logic                  scan_hit,
  input  logic [ACNT_WIDTH-1:0] acnt,
  output logic                  out,
  output logic                  armed
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, ACTIVE = 2'd2} ch_state_t;

  ch_state_t             state;
  logic [ACNT_WIDTH-1:0] set_q;
  logic [ACNT_WIDTH-1:0] clr_q;

`ifdef HWAG_SCHED_REARM_EN
  localparam ch_state_t AFTER_CLR = ARMED;
`else
  localparam ch_state_t AFTER_CLR = IDLE;
`endif

  // Sync loss beats a write, a write beats this cycle's compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      set_q <= '0;
      clr_q <= '0;
      out   <= 1'b0;
    end else if (ena) begin
      if (wr_hit) begin
        set_q <= wr_set;
        clr_q <= wr_clr;
      end
      if (!sync) begin
        state <= IDLE;
        out   <= 1'b0;
      end else if (wr_hit) begin
        state <= wr_arm ? ARMED : IDLE;
        out   <= 1'b0;
      end else if (scan_hit) begin
        case (state)
          ARMED: if (acnt == set_q) begin
            state <= ACTIVE;
            out   <= 1'b1;
          end
          ACTIVE: if (acnt == clr_q) begin
            state <= AFTER_CLR;
            out   <= 1'b0;
          end
          IDLE: ;
          default: begin
            state <= IDLE;
            out   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign armed = (state == ARMED) || (state == ACTIVE);
endmodule

// Top: scanner, write range check and the channel array.
module hwag_angle_sched #(
  parameter int                  CH_NUM     = 8,
  parameter int                  ACNT_WIDTH = 24,
  parameter logic [ACNT_WIDTH-1:0] ACNT_MAX = 24'd3839,
  localparam int                 IDX_W      = $clog2(CH_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  hwag_start,
  input  logic [ACNT_WIDTH-1:0] acnt,
  input  logic                  wr_ena,
  input  logic [IDX_W-1:0]      wr_ch,
  input  logic [ACNT_WIDTH-1:0] wr_set,
  input  logic [ACNT_WIDTH-1:0] wr_clr,
  input  logic                  wr_arm,
  output logic [CH_NUM-1:0]     ch_out,
  output logic [CH_NUM-1:0]     ch_armed,
  output logic                  wr_err,
  output logic [IDX_W-1:0]      scan_idx
);
  logic wr_ok;
  assign wr_ok = wr_ena && (wr_set <= ACNT_MAX) && (wr_clr <= ACNT_MAX);

  // Round-robin scanner; CH_NUM is a power of two so the add wraps itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     scan_idx <= '0;
    else if (ena) scan_idx <= scan_idx + IDX_W'(1);
  end

  // Sticky error reflects the most recent accepted-or-rejected write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 wr_err <= 1'b0;
    else if (ena && wr_ena)   wr_err <= !wr_ok;
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    hwag_sched_ch #(.ACNT_WIDTH(ACNT_WIDTH)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .sync     (hwag_start),
      .wr_hit   (wr_ok && (wr_ch == IDX_W'(i))),
      .wr_set   (wr_set),
      .wr_clr   (wr_clr),
      .wr_arm   (wr_arm),
      .scan_hit (scan_idx == IDX_W'(i)),
      .acnt     (acnt),
      .out      (ch_out[i]),
      .armed    (ch_armed[i])
    );
  end
endmodule

// File: tb/tb_hwag_angle_sched.sv
// Bench for hwag_angle_sched: directed scenarios plus random traffic, checked
// cycle by cycle against a channel-level model through a scoreboard queue.
module tb_hwag_angle_sched;
  localparam int CH_NUM = 8;
  localparam int AW     = 24;
  localparam int AMAX   = 3839;
  localparam int IW     = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b1;
  logic          hwag_start = 1'b0;
  logic [AW-1:0] acnt = '0;
  logic          wr_ena = 1'b0;
  logic [IW-1:0] wr_ch = '0;
  logic [AW-1:0] wr_set = '0;
  logic [AW-1:0] wr_clr = '0;
  logic          wr_arm = 1'b0;
  logic [CH_NUM-1:0] ch_out, ch_armed;
  logic          wr_err;
  logic [IW-1:0] scan_idx;

  hwag_angle_sched #(.CH_NUM(CH_NUM), .ACNT_WIDTH(AW), .ACNT_MAX(24'd3839)) dut (
    .clk(clk), .rst(rst), .ena(ena), .hwag_start(hwag_start), .acnt(acnt),
    .wr_ena(wr_ena), .wr_ch(wr_ch), .wr_set(wr_set), .wr_clr(wr_clr),
    .wr_arm(wr_arm), .ch_out(ch_out), .ch_armed(ch_armed), .wr_err(wr_err),
    .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_NUM-1:0] out;
    logic [CH_NUM-1:0] armed;
    logic              err;
    logic [IW-1:0]     scan;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Model: each channel is "off", "waiting" for its set angle or "high".
  localparam int OFF = 0, WAITING = 1, HIGH = 2;
  int m_mode[CH_NUM];
  int m_set[CH_NUM];
  int m_clr[CH_NUM];
  int m_scan;
  bit m_err;

  task automatic model_reset();
    for (int i = 0; i < CH_NUM; i++) begin
      m_mode[i] = OFF; m_set[i] = 0; m_clr[i] = 0;
    end
    m_scan = 0; m_err = 0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    bit   wvalid;
    exp_t e;
    if (ena) begin
      wvalid = 0;
      if (wr_ena) begin
        if (int'(wr_set) > AMAX || int'(wr_clr) > AMAX) m_err = 1;
        else begin
          wvalid = 1; m_err = 0;
          m_set[wr_ch] = int'(wr_set);
          m_clr[wr_ch] = int'(wr_clr);
        end
      end
      for (int i = 0; i < CH_NUM; i++) begin
        if (!hwag_start) m_mode[i] = OFF;
        else if (wvalid && int'(wr_ch) == i) m_mode[i] = wr_arm ? WAITING : OFF;
        else if (i == m_scan) begin
          if (m_mode[i] == WAITING && int'(acnt) == m_set[i]) m_mode[i] = HIGH;
          else if (m_mode[i] == HIGH && int'(acnt) == m_clr[i]) begin
`ifdef HWAG_SCHED_REARM_EN
            m_mode[i] = WAITING;
`else
            m_mode[i] = OFF;
`endif
          end
        end
      end
      m_scan = (m_scan + 1) % CH_NUM;
    end
    for (int i = 0; i < CH_NUM; i++) begin
      e.out[i]   = (m_mode[i] == HIGH);
      e.armed[i] = (m_mode[i] != OFF);
    end
    e.err  = m_err;
    e.scan = IW'(m_scan);
    exp_q.push_back(e);
  endtask

  // One clock: inputs were set at a negedge, model predicts, next negedge.
  task automatic tick();
    model_step();
    @(negedge clk);
    wr_ena = 1'b0;
  endtask

  task automatic hold(input int a, input int n);
    acnt = AW'(a);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_write(input int ch, input int s, input int c, input bit arm);
    wr_ena = 1'b1; wr_ch = IW'(ch); wr_set = AW'(s); wr_clr = AW'(c); wr_arm = arm;
    tick();
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a result, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ch_out",   int'(ch_out),   int'(e.out));
        chk("ch_armed", int'(ch_armed), int'(e.armed));
        chk("wr_err",   int'(wr_err),   int'(e.err));
        chk("scan_idx", int'(scan_idx), int'(e.scan));
      end
    end
  end

  initial begin
    int a, n, wait_cyc;
    model_reset();
    #12;
    chk("rst ch_out", int'(ch_out), 0);
    chk("rst ch_armed", int'(ch_armed), 0);
    chk("rst wr_err", int'(wr_err), 0);
    chk("rst scan_idx", int'(scan_idx), 0);
    @(negedge clk);
    rst = 1'b1;
    hwag_start = 1'b1;

    // Set/clear pulse on ch2.
    do_write(2, 100, 200, 1);
    for (int v = 0; v <= 260; v++) hold(v, 8);

    // Range check then a valid write.
    do_write(0, 5, 3840, 1);
    hold(5, 10);
    do_write(0, 5, 6, 0);
    hold(5, 4);

    // Sync loss while ch5 is high.
    do_write(5, 10, 3000, 1);
    hold(10, 8);
    for (int v = 17; v <= 500; v += 7) hold(v, 8);
    hwag_start = 1'b0;
    hold(500, 3);
    hwag_start = 1'b1;
    for (int v = 0; v <= 3100; v += 50) hold(v, 8);
    hold(10, 8);

    // Write collision on ch3 at acnt==40.
    acnt = AW'(40);
    while (m_scan != 3) tick();
    do_write(3, 40, 45, 1);
    hold(40, 8);
    hold(45, 8);

    // Wrap with set==clr==0 on ch1, two revolutions.
    do_write(1, 0, 0, 1);
    for (int r = 0; r < 2; r++) begin
      hold(0, 8);
      for (int v = 1; v < AMAX; v += 131) hold(v, 8);
      hold(AMAX, 8);
    end
    hold(0, 8);

    // Random traffic with an async reset in the middle.
    for (int it = 0; it < 400; it++) begin
      if (it == 200) begin
        rst = 1'b0;
        #1;
        chk("async ch_out", int'(ch_out), 0);
        chk("async ch_armed", int'(ch_armed), 0);
        chk("async scan_idx", int'(scan_idx), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
      end
      a = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, AMAX)) : int'($urandom_range(0, 7));
      acnt = AW'(a);
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        ena = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 49) == 0) hwag_start = ~hwag_start;
        if (hwag_start && $urandom_range(0, 5) == 0) begin
          wr_ena = 1'b1;
          wr_ch  = IW'($urandom_range(0, CH_NUM - 1));
          wr_set = AW'($urandom_range(0, 9) == 0 ? AMAX + 1 + int'($urandom_range(0, 5)) : int'($urandom_range(0, 7)));
          wr_clr = AW'($urandom_range(0, 9) == 0 ? AMAX + 1 : int'($urandom_range(0, 7)));
          wr_arm = ($urandom_range(0, 3) != 0);
        end
        tick();
      end
    end
    ena = 1'b1;

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("scoreboard drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
